// File: rtl/load_store_unit.sv
// load_store_unit: RV32I memory stage running LB/LH/LW/LBU/LHU/SB/SH/SW over a req/ack bus.
// Optional macro LSU_TIMEOUT_EN aborts a request left unacknowledged for TIMEOUT_CYCLES cycles.
module load_store_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_i,
  input  logic        mem_read_i,
  input  logic        mem_write_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] store_data_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] load_data_o,
  output logic        error_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [31:0] r_addr;
  logic [31:0] r_sdata;
  logic [31:0] r_load_data;
  logic [2:0]  r_funct3;
  logic        r_we;
  logic        r_error;

  logic        w_accept;
  logic        w_req;
  logic        w_any_op;
  logic        w_f3_ok;
  logic        w_misal;
  logic        w_bus_op;
  logic        w_dec_err;
  logic        w_timeout;
  logic [31:0] w_shifted;
  logic [31:0] w_load_ext;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;

  assign w_accept = (r_state == S_IDLE) && start_i;
  assign w_req    = (r_state == S_REQ);
  assign w_any_op = mem_write_i || mem_read_i;

  // A store wins when both op strobes are high, so it selects the legal funct3 set.
  always_comb begin
    w_f3_ok = 1'b0;
    if (mem_write_i) begin
      w_f3_ok = (funct3_i == 3'b000) || (funct3_i == 3'b001) || (funct3_i == 3'b010);
    end else begin
      w_f3_ok = (funct3_i == 3'b000) || (funct3_i == 3'b001) || (funct3_i == 3'b010) ||
                (funct3_i == 3'b100) || (funct3_i == 3'b101);
    end
  end

  assign w_misal   = ((funct3_i[1:0] == 2'b01) && addr_i[0]) ||
                     ((funct3_i[1:0] == 2'b10) && (addr_i[1:0] != 2'b00));
  assign w_bus_op  = w_any_op && w_f3_ok && !w_misal;
  assign w_dec_err = w_any_op && !w_bus_op;

`ifdef LSU_TIMEOUT_EN
  logic [7:0] r_cnt;

  // Fires on the TIMEOUT_CYCLES-th REQ cycle; an ack in that same cycle takes priority.
  assign w_timeout = w_req && !mem_ack_i && (({24'd0, r_cnt} + 32'd1) >= TIMEOUT_CYCLES);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (w_accept) begin
      r_cnt <= '0;
    end else if (w_req && !mem_ack_i) begin
      r_cnt <= r_cnt + 8'd1;
    end
  end
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (start_i) begin
          w_next = w_bus_op ? S_REQ : S_DONE;
        end
      end
      S_REQ: begin
        if (mem_ack_i || w_timeout) begin
          w_next = S_DONE;
        end
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_addr      <= '0;
      r_sdata     <= '0;
      r_funct3    <= '0;
      r_we        <= 1'b0;
      r_error     <= 1'b0;
      r_load_data <= '0;
    end else begin
      if (w_accept) begin
        r_addr   <= addr_i;
        r_sdata  <= store_data_i;
        r_funct3 <= funct3_i;
        r_we     <= mem_write_i;
        r_error  <= w_dec_err;
      end else if (w_req) begin
        if (mem_ack_i) begin
          r_error <= 1'b0;
          if (!r_we) begin
            r_load_data <= w_load_ext;
          end
        end else if (w_timeout) begin
          r_error <= 1'b1;
        end
      end else if (r_state == S_DONE) begin
        r_error <= 1'b0;
      end
    end
  end

  // Halfword lanes are 2-byte aligned here, so one byte-granular shift serves both widths.
  assign w_shifted = mem_rdata_i >> {r_addr[1:0], 3'b000};

  always_comb begin
    w_load_ext = mem_rdata_i;
    case (r_funct3)
      3'b000:  w_load_ext = {{24{w_shifted[7]}}, w_shifted[7:0]};
      3'b100:  w_load_ext = {24'd0, w_shifted[7:0]};
      3'b001:  w_load_ext = {{16{w_shifted[15]}}, w_shifted[15:0]};
      3'b101:  w_load_ext = {16'd0, w_shifted[15:0]};
      default: w_load_ext = mem_rdata_i;
    endcase
  end

  always_comb begin
    w_be    = 4'b1111;
    w_wdata = r_sdata;
    case (r_funct3[1:0])
      2'b00: begin
        w_be    = 4'b0001 << r_addr[1:0];
        w_wdata = {4{r_sdata[7:0]}};
      end
      2'b01: begin
        w_be    = 4'b0011 << {r_addr[1], 1'b0};
        w_wdata = {2{r_sdata[15:0]}};
      end
      default: begin
        w_be    = 4'b1111;
        w_wdata = r_sdata;
      end
    endcase
  end

  assign busy_o      = w_req;
  assign done_o      = (r_state == S_DONE);
  assign error_o     = r_error;
  assign load_data_o = r_load_data;
  assign mem_req_o   = w_req;
  assign mem_we_o    = w_req && r_we;
  assign mem_addr_o  = w_req ? {r_addr[31:2], 2'b00} : '0;
  assign mem_be_o    = w_req ? w_be : '0;
  assign mem_wdata_o = w_req ? w_wdata : '0;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: scoreboard of expected results per memory op.
// Defining LSU_TIMEOUT_EN also runs the request-timeout scenario (TIMEOUT_CYCLES overridden to 4).
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_i;
  logic        mem_read_i;
  logic        mem_write_i;
  logic [2:0]  funct3_i;
  logic [31:0] addr_i;
  logic [31:0] store_data_i;
  logic        busy_o;
  logic        done_o;
  logic [31:0] load_data_o;
  logic        error_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_wdata_o;
  logic        mem_ack_i;
  logic [31:0] mem_rdata_i;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic        we;
    logic        re;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] d;
    logic [7:0]  waits;
    logic [31:0] rd;
    logic        poke;
  } stim_t;

  typedef struct packed {
    logic        bus;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        err;
    logic [31:0] ld;
    logic [7:0]  lat;
    logic [7:0]  busy;
  } res_t;

  stim_t       stim_q[$];
  res_t        exp_q[$];
  logic [31:0] model_ld;

  always #5 clk = ~clk;

  load_store_unit #(.TIMEOUT_CYCLES(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .start_i      (start_i),
    .mem_read_i   (mem_read_i),
    .mem_write_i  (mem_write_i),
    .funct3_i     (funct3_i),
    .addr_i       (addr_i),
    .store_data_i (store_data_i),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .load_data_o  (load_data_o),
    .error_o      (error_o),
    .mem_req_o    (mem_req_o),
    .mem_we_o     (mem_we_o),
    .mem_addr_o   (mem_addr_o),
    .mem_be_o     (mem_be_o),
    .mem_wdata_o  (mem_wdata_o),
    .mem_ack_i    (mem_ack_i),
    .mem_rdata_i  (mem_rdata_i)
  );

  // Reference behaviour of one op, written from the instruction semantics.
  function automatic res_t model(input stim_t s, input logic [31:0] prev);
    res_t r;
    logic is_w, is_r, legal, mis;
    logic [7:0]  b;
    logic [15:0] h;
    r = '0; r.ld = prev; r.lat = 8'd1;
    is_w = s.we;
    is_r = s.re && !s.we;
    if (!is_w && !is_r) return r;
    legal = is_w ? (s.f3 <= 3'd2) : (s.f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    mis = ((s.f3[1:0] == 2'd1) && s.a[0]) || ((s.f3[1:0] == 2'd2) && (s.a[1:0] != 2'd0));
    if (!legal || mis) begin
      r.err = 1'b1;
      return r;
    end
    r.bus  = 1'b1;
    r.we   = is_w;
    r.addr = {s.a[31:2], 2'b00};
    r.lat  = s.waits + 8'd2;
    r.busy = s.waits + 8'd1;
    case (s.f3[1:0])
      2'd0: begin
        case (s.a[1:0])
          2'd0: r.be = 4'b0001;
          2'd1: r.be = 4'b0010;
          2'd2: r.be = 4'b0100;
          default: r.be = 4'b1000;
        endcase
        r.wdata = {s.d[7:0], s.d[7:0], s.d[7:0], s.d[7:0]};
      end
      2'd1: begin
        r.be = s.a[1] ? 4'b1100 : 4'b0011;
        r.wdata = {s.d[15:0], s.d[15:0]};
      end
      default: begin
        r.be = 4'b1111;
        r.wdata = s.d;
      end
    endcase
    if (is_r) begin
      case (s.a[1:0])
        2'd0: b = s.rd[7:0];
        2'd1: b = s.rd[15:8];
        2'd2: b = s.rd[23:16];
        default: b = s.rd[31:24];
      endcase
      h = s.a[1] ? s.rd[31:16] : s.rd[15:0];
      case (s.f3)
        3'd0: r.ld = b[7] ? {24'hFFFFFF, b} : {24'h0, b};
        3'd4: r.ld = {24'h0, b};
        3'd1: r.ld = h[15] ? {16'hFFFF, h} : {16'h0, h};
        3'd5: r.ld = {16'h0, h};
        default: r.ld = s.rd;
      endcase
    end
    return r;
  endfunction

  // Drives one op, plays the memory side, and records what the DUT showed.
  task automatic exec(input stim_t s, output res_t o, output logic dirty);
    int w;
    int n;
    o = '0;
    start_i = 1'b1; mem_write_i = s.we; mem_read_i = s.re;
    funct3_i = s.f3; addr_i = s.a; store_data_i = s.d;
    @(posedge clk); #1;
    if (s.poke) begin
      mem_write_i = 1'b1; mem_read_i = 1'b1; funct3_i = 3'b000;
      addr_i = 32'hFFFF_FFF3; store_data_i = 32'h5A5A_5A5A;
    end else begin
      start_i = 1'b0;
    end
    w = int'(s.waits);
    n = 1;
    while (n <= 60 && o.lat == 8'd0) begin
      if (done_o) begin
        o.lat = 8'(n); o.err = error_o; o.ld = load_data_o;
      end else begin
        if (busy_o) o.busy = o.busy + 8'd1;
        if (mem_req_o) begin
          o.bus = 1'b1; o.we = mem_we_o; o.addr = mem_addr_o;
          o.be = mem_be_o; o.wdata = mem_wdata_o;
          if (w == 0) begin
            mem_ack_i = 1'b1; mem_rdata_i = s.rd;
          end else begin
            w--;
          end
        end
        @(posedge clk); #1;
        mem_ack_i = 1'b0; mem_rdata_i = $urandom;
        n++;
      end
    end
    start_i = 1'b0;
    @(posedge clk); #1;
    dirty = done_o | error_o | busy_o | mem_req_o;
  endtask

  task automatic add(input logic we, re, input logic [2:0] f3, input logic [31:0] a, d,
                     input int waits, input logic [31:0] rd, input logic poke,
                     input logic ebus, input logic [3:0] ebe, input logic [31:0] ewd,
                     input logic eerr, input logic [31:0] eld, input int elat, input int ebusy);
    stim_t s;
    res_t  e;
    s = '{we: we, re: re, f3: f3, a: a, d: d, waits: 8'(waits), rd: rd, poke: poke};
    e = '0;
    e.bus = ebus; e.we = ebus & we; e.addr = ebus ? {a[31:2], 2'b00} : 32'd0;
    e.be = ebe; e.wdata = ewd; e.err = eerr; e.ld = eld;
    e.lat = 8'(elat); e.busy = 8'(ebusy);
    stim_q.push_back(s);
    exp_q.push_back(e);
  endtask

  task automatic test_reset;
    reset = 1'b1; start_i = 1'b1; mem_read_i = 1'b1; mem_write_i = 1'b0;
    funct3_i = 3'b010; addr_i = 32'h100; store_data_i = 32'h1; mem_ack_i = 1'b1; mem_rdata_i = 32'hFFFF_FFFF;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({busy_o, done_o, error_o, mem_req_o, mem_we_o} !== 5'b0) begin
      errors++; $display("FAIL reset_ctrl got %b want 00000", {busy_o, done_o, error_o, mem_req_o, mem_we_o});
    end
    checks++;
    if ({mem_addr_o, mem_be_o, mem_wdata_o, load_data_o} !== '0) begin
      errors++; $display("FAIL reset_data got %h/%h/%h/%h want all 0", mem_addr_o, mem_be_o, mem_wdata_o, load_data_o);
    end
    start_i = 1'b0; mem_ack_i = 1'b0; reset = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({busy_o, done_o, mem_req_o} !== 3'b0) begin
      errors++; $display("FAIL reset_idle got %b want 000", {busy_o, done_o, mem_req_o});
    end
  endtask

  task automatic test_directed;
    stim_t s;
    res_t  o, e;
    logic  dirty;
    int    i;
    add(1, 0, 3'b010, 32'h100, 32'hDEADBEEF, 0, 32'h0,        0, 1, 4'b1111, 32'hDEADBEEF, 0, 32'h0,        2, 1);
    add(0, 1, 3'b000, 32'h103, 32'h0,        3, 32'h80FF0000, 1, 1, 4'b1000, 32'h0,        0, 32'hFFFFFF80, 5, 4);
    add(0, 1, 3'b101, 32'h102, 32'h0,        1, 32'h80011234, 0, 1, 4'b1100, 32'h0,        0, 32'h00008001, 3, 2);
    add(1, 0, 3'b001, 32'h102, 32'h0000ABCD, 0, 32'h0,        0, 1, 4'b1100, 32'hABCDABCD, 0, 32'h00008001, 2, 1);
    add(0, 1, 3'b010, 32'h101, 32'h0,        0, 32'h0,        0, 0, 4'b0000, 32'h0,        1, 32'h00008001, 1, 0);
    add(0, 0, 3'b010, 32'h100, 32'h0,        0, 32'h0,        0, 0, 4'b0000, 32'h0,        0, 32'h00008001, 1, 0);
    add(0, 1, 3'b011, 32'h200, 32'h0,        0, 32'h0,        0, 0, 4'b0000, 32'h0,        1, 32'h00008001, 1, 0);
    add(1, 0, 3'b100, 32'h200, 32'h0,        0, 32'h0,        0, 0, 4'b0000, 32'h0,        1, 32'h00008001, 1, 0);
    add(1, 0, 3'b001, 32'h101, 32'h0,        0, 32'h0,        0, 0, 4'b0000, 32'h0,        1, 32'h00008001, 1, 0);
    add(0, 1, 3'b001, 32'h202, 32'h0,        2, 32'hF00D1234, 0, 1, 4'b1100, 32'h0,        0, 32'hFFFFF00D, 4, 3);
    add(0, 1, 3'b000, 32'h201, 32'h0,        0, 32'h00007F00, 0, 1, 4'b0010, 32'h0,        0, 32'h0000007F, 2, 1);
    add(0, 1, 3'b100, 32'h000, 32'h0,        0, 32'h000000FE, 0, 1, 4'b0001, 32'h0,        0, 32'h000000FE, 2, 1);
    add(1, 1, 3'b000, 32'h301, 32'h12345678, 0, 32'h0,        0, 1, 4'b0010, 32'h78787878, 0, 32'h000000FE, 2, 1);
    add(1, 0, 3'b010, 32'h302, 32'h0,        0, 32'h0,        0, 0, 4'b0000, 32'h0,        1, 32'h000000FE, 1, 0);
    add(0, 1, 3'b010, 32'h304, 32'h0,        0, 32'hCAFEF00D, 0, 1, 4'b1111, 32'h0,        0, 32'hCAFEF00D, 2, 1);
    i = 0;
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front();
      exec(s, o, dirty);
      e = exp_q.pop_front();
      checks++; if (o.lat !== e.lat) begin errors++; $display("FAIL dir%0d latency got %0d want %0d", i, o.lat, e.lat); end
      checks++; if (o.err !== e.err) begin errors++; $display("FAIL dir%0d error got %b want %b", i, o.err, e.err); end
      checks++; if (o.ld !== e.ld) begin errors++; $display("FAIL dir%0d load_data got %h want %h", i, o.ld, e.ld); end
      checks++; if (o.busy !== e.busy) begin errors++; $display("FAIL dir%0d busy_cycles got %0d want %0d", i, o.busy, e.busy); end
      checks++; if (o.bus !== e.bus) begin errors++; $display("FAIL dir%0d bus_used got %b want %b", i, o.bus, e.bus); end
      if (e.bus) begin
        checks++;
        if ({o.we, o.addr, o.be} !== {e.we, e.addr, e.be}) begin
          errors++; $display("FAIL dir%0d we/addr/be got %b/%h/%b want %b/%h/%b", i, o.we, o.addr, o.be, e.we, e.addr, e.be);
        end
        if (e.we) begin
          checks++; if (o.wdata !== e.wdata) begin errors++; $display("FAIL dir%0d wdata got %h want %h", i, o.wdata, e.wdata); end
        end
      end
      checks++; if (dirty !== 1'b0) begin errors++; $display("FAIL dir%0d after_done got %b want 0", i, dirty); end
      model_ld = e.ld;
      i++;
    end
  endtask

  task automatic test_reset_mid;
    stim_t s;
    res_t  o, e;
    logic  dirty;
    start_i = 1'b1; mem_read_i = 1'b1; mem_write_i = 1'b0; funct3_i = 3'b010; addr_i = 32'h400;
    @(posedge clk); #1;
    start_i = 1'b0;
    checks++; if (mem_req_o !== 1'b1) begin errors++; $display("FAIL midrst_req got %b want 1", mem_req_o); end
    @(posedge clk); #1;
    reset = 1'b1; mem_ack_i = 1'b1; mem_rdata_i = 32'h99999999;
    @(posedge clk); #1;
    reset = 1'b0;
    checks++;
    if ({mem_req_o, busy_o, done_o, error_o} !== 4'b0) begin
      errors++; $display("FAIL midrst_ctrl got %b want 0000", {mem_req_o, busy_o, done_o, error_o});
    end
    checks++; if (load_data_o !== 32'h0) begin errors++; $display("FAIL midrst_ld got %h want 0", load_data_o); end
    @(posedge clk); #1;
    mem_ack_i = 1'b0;
    checks++; if ({done_o, busy_o} !== 2'b0) begin errors++; $display("FAIL midrst_lateack got %b want 00", {done_o, busy_o}); end
    model_ld = 32'h0;
    s = '{we: 1'b0, re: 1'b1, f3: 3'b010, a: 32'h400, d: 32'h0, waits: 8'd0, rd: 32'h11223344, poke: 1'b0};
    exp_q.push_back(model(s, model_ld));
    exec(s, o, dirty);
    e = exp_q.pop_front();
    checks++; if (o.lat !== e.lat) begin errors++; $display("FAIL midrst_next latency got %0d want %0d", o.lat, e.lat); end
    checks++; if (o.ld !== e.ld) begin errors++; $display("FAIL midrst_next load_data got %h want %h", o.ld, e.ld); end
    model_ld = e.ld;
  endtask

  task automatic test_back_to_back;
    stim_t s;
    res_t  o, e;
    logic  dirty;
    for (int i = 0; i < 40; i++) begin
      s.we = 1'($urandom_range(0, 1));
      s.re = ($urandom_range(0, 7) != 0);
      s.f3 = 3'($urandom_range(0, 7));
      s.a = $urandom;
      s.d = $urandom;
      s.waits = 8'($urandom_range(0, 3));
      s.rd = $urandom;
      s.poke = 1'($urandom_range(0, 1));
      exp_q.push_back(model(s, model_ld));
      exec(s, o, dirty);
      e = exp_q.pop_front();
      checks++; if (o.lat !== e.lat) begin errors++; $display("FAIL rnd%0d latency got %0d want %0d", i, o.lat, e.lat); end
      checks++; if (o.err !== e.err) begin errors++; $display("FAIL rnd%0d error got %b want %b", i, o.err, e.err); end
      checks++; if (o.ld !== e.ld) begin errors++; $display("FAIL rnd%0d load_data got %h want %h", i, o.ld, e.ld); end
      checks++; if (o.busy !== e.busy) begin errors++; $display("FAIL rnd%0d busy_cycles got %0d want %0d", i, o.busy, e.busy); end
      checks++; if (o.bus !== e.bus) begin errors++; $display("FAIL rnd%0d bus_used got %b want %b", i, o.bus, e.bus); end
      if (e.bus) begin
        checks++;
        if ({o.we, o.addr, o.be} !== {e.we, e.addr, e.be}) begin
          errors++; $display("FAIL rnd%0d we/addr/be got %b/%h/%b want %b/%h/%b", i, o.we, o.addr, o.be, e.we, e.addr, e.be);
        end
        if (e.we) begin
          checks++; if (o.wdata !== e.wdata) begin errors++; $display("FAIL rnd%0d wdata got %h want %h", i, o.wdata, e.wdata); end
        end
      end
      checks++; if (dirty !== 1'b0) begin errors++; $display("FAIL rnd%0d after_done got %b want 0", i, dirty); end
      model_ld = e.ld;
    end
  endtask

`ifdef LSU_TIMEOUT_EN
  task automatic test_timeout;
    stim_t s;
    res_t  o;
    logic  dirty;
    s = '{we: 1'b0, re: 1'b1, f3: 3'b010, a: 32'h500, d: 32'h0, waits: 8'd200, rd: 32'h0, poke: 1'b0};
    exec(s, o, dirty);
    checks++; if (o.lat !== 8'd5) begin errors++; $display("FAIL timeout latency got %0d want 5", o.lat); end
    checks++; if (o.busy !== 8'd4) begin errors++; $display("FAIL timeout req_cycles got %0d want 4", o.busy); end
    checks++; if (o.err !== 1'b1) begin errors++; $display("FAIL timeout error got %b want 1", o.err); end
    checks++; if (o.ld !== model_ld) begin errors++; $display("FAIL timeout load_data got %h want %h", o.ld, model_ld); end
    checks++; if (dirty !== 1'b0) begin errors++; $display("FAIL timeout after_done got %b want 0", dirty); end
    s = '{we: 1'b0, re: 1'b1, f3: 3'b010, a: 32'h504, d: 32'h0, waits: 8'd3, rd: 32'h600DF00D, poke: 1'b0};
    exec(s, o, dirty);
    checks++; if (o.err !== 1'b0) begin errors++; $display("FAIL limit_ack error got %b want 0", o.err); end
    checks++; if (o.ld !== 32'h600DF00D) begin errors++; $display("FAIL limit_ack load_data got %h want 600df00d", o.ld); end
    model_ld = 32'h600DF00D;
  endtask
`endif

  initial begin
    reset = 1'b1; start_i = 1'b0; mem_read_i = 1'b0; mem_write_i = 1'b0; funct3_i = '0;
    addr_i = '0; store_data_i = '0; mem_ack_i = 1'b0; mem_rdata_i = '0; model_ld = '0;
    test_reset;
    test_directed;
    test_reset_mid;
    test_back_to_back;
`ifdef LSU_TIMEOUT_EN
    test_timeout;
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1);
  end

endmodule
